click_decoder: RTL
==================

// Module: click_decoder
// PURPOSE
//  Consumes the single-cycle press pulses produced by the button debouncers and decodes
//  them into click gestures: N pulses separated by gaps < GAP_CYCLES form one event.
//  Sits between the debouncers and the game/control FSM; one instance per button.
//  Emits one event per gesture with click count (1..MAX_CLICKS) plus single/double strobes.
// PARAMETERS
//  GAP_CYCLES     30_000_000  max clk cycles between pulses of one gesture (300 ms @ 100 MHz)
//  TIMER_W        25          gap/holdoff timer width; must hold GAP_CYCLES and HOLDOFF_CYCLES
//  MAX_CLICKS     3           count at which a gesture is emitted immediately (>=2)
//  CNT_W          2           evt_count width; must hold MAX_CLICKS
//  HOLDOFF_CYCLES 5_000_000   post-event ignore window (used only with CLICK_DEC_HOLDOFF_EN)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  in_pulse   in   1      one-cycle press pulse from debouncer (already synchronous to clk)
//  evt_valid  out  1      one-cycle strobe: gesture complete
//  evt_count  out  CNT_W  clicks in gesture; valid only while evt_valid=1, else 0
//  evt_single out  1      = evt_valid & (evt_count==1)
//  evt_double out  1      = evt_valid & (evt_count==2)
//  busy       out  1      1 in any state other than IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, count=0, timer=0, all outputs 0.
//  Reset mid-gesture discards the partial gesture; no event is emitted.
//  States: IDLE, COLLECT, EMIT (+ HOLDOFF when CLICK_DEC_HOLDOFF_EN).
//  IDLE:    in_pulse -> count=1, timer=GAP_CYCLES-1, go COLLECT.
//  COLLECT: in_pulse -> count=count+1, timer reloaded to GAP_CYCLES-1;
//           if count+1==MAX_CLICKS -> go EMIT (no wait for gap expiry).
//           no pulse, timer!=0 -> timer-1.  no pulse, timer==0 -> go EMIT.
//           Pulse on the expiry cycle (timer==0) counts toward the gesture (pulse wins).
//  EMIT:    registered outputs: evt_valid=1, evt_count=count, strobes decoded, exactly 1 cycle.
//           Latency: event is visible GAP_CYCLES+1 cycles after last pulse (gap expiry case)
//           or 1 cycle after the MAX_CLICKS-th pulse.
//           in_pulse in EMIT cycle: starts a new gesture (count=1, COLLECT); never dropped.
//           otherwise -> IDLE, count=0.
//  Count never exceeds MAX_CLICKS; no wrap. evt_count=0 whenever evt_valid=0.
//  Back-to-back pulses on consecutive cycles are each counted.
// CONFIGURATION
//  CLICK_DEC_HOLDOFF_EN defined: EMIT -> HOLDOFF (timer=HOLDOFF_CYCLES-1); in_pulse ignored
//   and busy=1 until timer==0, then IDLE. Pulse in EMIT cycle is ignored (enters HOLDOFF).
//  Undefined: no HOLDOFF state, HOLDOFF_CYCLES unused, EMIT behaves as above.
// STRUCTURE
//  click_dec_pkg: state enum (IDLE/COLLECT/EMIT/HOLDOFF), default widths, GAP/HOLDOFF consts.
//  Sub-module gap_timer: loadable TIMER_W down-counter (load, load_val, dec, zero);
//   shared by gap and holdoff windows. FSM + count + output regs in click_decoder.
// TESTING  (GAP_CYCLES=10, MAX_CLICKS=3, HOLDOFF_CYCLES=5, TIMER_W=4)
//  1 pulse at t0 -> evt_valid=1, evt_count=1, evt_single=1 at t0+11 for 1 cycle; busy t0+1..t0+11.
//  pulses t0, t0+6 -> evt_double=1, evt_count=2 at t0+17; nothing earlier.
//  pulses t0, t0+1, t0+2 -> evt_count=3 at t0+3 (immediate), evt_single/double=0.
//  pulse t0, next pulse at t0+10 (expiry cycle) -> counted: single event at t0+21, count=2.
//  pulse in EMIT cycle -> new gesture; w/o HOLDOFF_EN second event count=1 follows; with EN none.
//  rst_n low at t0+5 after pulse at t0 -> outputs 0 async, no event after release.

Source files
------------

// File: rtl/click_dec_pkg.sv
// click_dec_pkg: shared state encoding and default sizing for the click decoder.
package click_dec_pkg;

    // Decoder states; HOLDOFF is only reachable when CLICK_DEC_HOLDOFF_EN is defined.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2,
        HOLDOFF = 2'd3
    } state_e;

    // Defaults sized for a 100 MHz clock: 300 ms gesture gap, 50 ms post-event ignore.
    localparam int DEF_GAP_CYCLES     = 30_000_000;
    localparam int DEF_TIMER_W        = 25;
    localparam int DEF_MAX_CLICKS     = 3;
    localparam int DEF_CNT_W          = 2;
    localparam int DEF_HOLDOFF_CYCLES = 5_000_000;

endpackage

// File: rtl/gap_timer.sv
// gap_timer: loadable down-counter that stops at zero. Serves both the inter-pulse
// gap window and the post-event holdoff window of click_decoder.
module gap_timer #(
    parameter int TIMER_W = click_dec_pkg::DEF_TIMER_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] cnt_q;

    // Load has priority over decrement; the counter saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/click_decoder.sv
// click_decoder: groups debounced press pulses into click gestures and emits one
// registered event per gesture (count plus single/double strobes).
// Optional feature: define CLICK_DEC_HOLDOFF_EN to add a post-event window during
// which new pulses are ignored.
module click_decoder
    import click_dec_pkg::*;
#(
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMER_W        = DEF_TIMER_W,
    parameter int MAX_CLICKS     = DEF_MAX_CLICKS,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_pulse,
    output logic             evt_valid,
    output logic [CNT_W-1:0] evt_count,
    output logic             evt_single,
    output logic             evt_double,
    output logic             busy
);

    localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_CLICKS);
    localparam logic [CNT_W-1:0]   ONE_CNT   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   TWO_CNT   = CNT_W'(2);
`ifdef CLICK_DEC_HOLDOFF_EN
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLDOFF_CYCLES - 1);
`endif

    // Reject configurations the timer/count widths or gesture rules cannot support.
    if (GAP_CYCLES < 2 || HOLDOFF_CYCLES < 1 || MAX_CLICKS < 2 ||
        MAX_CLICKS >= (1 << CNT_W)) begin : g_bad_cfg
        $error("click_decoder: unsupported parameter set");
    end

    state_e             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_inc;
    logic               evt_valid_q;
    logic [CNT_W-1:0]   evt_count_q;
    logic               evt_single_q;
    logic               evt_double_q;

    logic               t_load;
    logic [TIMER_W-1:0] t_load_val;
    logic               t_dec;
    logic               t_zero;

    assign count_inc = count_q + 1'b1;

    gap_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (t_load),
        .load_val_i (t_load_val),
        .dec_i      (t_dec),
        .zero_o     (t_zero)
    );

    // Timer control: every accepted pulse restarts the gap window; leaving EMIT
    // arms the holdoff window when that feature is built in.
    always_comb begin
        t_load     = 1'b0;
        t_load_val = GAP_LOAD;
        t_dec      = 1'b0;
        unique case (state_q)
            IDLE:    t_load = in_pulse;
            COLLECT: begin
                t_load = in_pulse;
                t_dec  = ~in_pulse;
            end
            EMIT: begin
`ifdef CLICK_DEC_HOLDOFF_EN
                t_load     = 1'b1;
                t_load_val = HOLD_LOAD;
`else
                t_load     = in_pulse;
`endif
            end
            HOLDOFF: t_dec = 1'b1;
            default: ;
        endcase
    end

    // Gesture FSM with registered event outputs; the event registers are loaded on
    // the same edge that enters EMIT, so they are high exactly while in EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            evt_valid_q  <= 1'b0;
            evt_count_q  <= '0;
            evt_single_q <= 1'b0;
            evt_double_q <= 1'b0;
        end else begin
            evt_valid_q  <= 1'b0;
            evt_count_q  <= '0;
            evt_single_q <= 1'b0;
            evt_double_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_pulse) begin
                        count_q <= ONE_CNT;
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    // A pulse on the expiry cycle still belongs to this gesture.
                    if (in_pulse) begin
                        count_q <= count_inc;
                        if (count_inc == MAX_CNT) begin
                            state_q      <= EMIT;
                            evt_valid_q  <= 1'b1;
                            evt_count_q  <= count_inc;
                            evt_single_q <= (count_inc == ONE_CNT);
                            evt_double_q <= (count_inc == TWO_CNT);
                        end
                    end else if (t_zero) begin
                        state_q      <= EMIT;
                        evt_valid_q  <= 1'b1;
                        evt_count_q  <= count_q;
                        evt_single_q <= (count_q == ONE_CNT);
                        evt_double_q <= (count_q == TWO_CNT);
                    end
                end
                EMIT: begin
`ifdef CLICK_DEC_HOLDOFF_EN
                    count_q <= '0;
                    state_q <= HOLDOFF;
`else
                    // A pulse coinciding with the event opens the next gesture.
                    if (in_pulse) begin
                        count_q <= ONE_CNT;
                        state_q <= COLLECT;
                    end else begin
                        count_q <= '0;
                        state_q <= IDLE;
                    end
`endif
                end
`ifdef CLICK_DEC_HOLDOFF_EN
                HOLDOFF: begin
                    if (t_zero) state_q <= IDLE;
                end
`endif
                default: begin
                    count_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_count  = evt_count_q;
    assign evt_single = evt_single_q;
    assign evt_double = evt_double_q;
    assign busy       = (state_q != IDLE);

endmodule
